fetch_unit: RTL and testbench

// - Instruction-fetch stage: holds the PC, reads an internal instruction memory and produces the
//   64-bit IF_ID pipeline register consumed by the decode stage.
// - IF_ID[63:32] = PC of the fetched instruction, IF_ID[31:0] = instruction word (opcode in [31:26]).
// - Handles load of program memory, stall, branch redirect/squash and HLT (opcode 6'b001101).

---
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, internal instruction memory and the
// registered IF_ID pipeline register with stall, branch squash and HLT handling.
//
// state   | meaning
// S_RUN   | fetching one instruction per cycle, pc advances
// S_HALTED| HLT retired; pc frozen, bubbles emitted until branch or reset
module fetch_unit #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] NOP_WORD = 32'h38000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [31:0]       br_target,
  input  logic              imem_we,
  input  logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_wdata,
  output logic [63:0]       IF_ID,
  output logic              if_valid,
  output logic              halted,
  output logic [31:0]       pc_out
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [5:0] OP_HLT   = 6'b001101;
  localparam logic [0:0] S_RUN    = 1'b0;
  localparam logic [0:0] S_HALTED = 1'b1;

  logic [31:0] imem [DEPTH];

  logic [31:0] pc_q, pc_d;
  logic [63:0] if_id_q, if_id_d;
  logic        valid_q, valid_d;
  logic [0:0]  state_q, state_d;

  logic [ADDR_W-1:0] fetch_idx;
  logic [31:0]       fetch_word;

  // Program-load port is deliberately outside the reset domain so a program
  // can be loaded while the core is held in reset.
  always_ff @(posedge clock) begin
    if (imem_we) begin
      imem[imem_addr] <= imem_wdata;
    end
  end

  assign fetch_idx  = pc_q[ADDR_W-1:0];
  assign fetch_word = imem[fetch_idx];

  always_comb begin
    pc_d    = pc_q;
    if_id_d = if_id_q;
    valid_d = valid_q;
    state_d = state_q;
    if (br_taken) begin
      pc_d    = br_target;
      if_id_d = {pc_q, NOP_WORD};
      valid_d = 1'b0;
      state_d = S_RUN;
    end else if (stall) begin
      pc_d    = pc_q;
    end else if (state_q == S_RUN) begin
      if_id_d = {pc_q, fetch_word};
      valid_d = 1'b1;
      if (fetch_word[31:26] == OP_HLT) begin
        state_d = S_HALTED;
      end else begin
        pc_d = pc_q + 32'd1;
      end
    end else begin
      if_id_d = {pc_q, NOP_WORD};
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      if_id_q <= {32'h0, NOP_WORD};
      valid_q <= 1'b0;
      state_q <= S_RUN;
    end else begin
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
      valid_q <= valid_d;
      state_q <= state_d;
    end
  end

  assign IF_ID    = if_id_q;
  assign if_valid = valid_q;
  assign halted   = (state_q == S_HALTED);
  assign pc_out   = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: each stimulus cycle queues the expected
// post-edge outputs; a monitor compares them one cycle later.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [63:0] IF_ID;
  logic        if_valid;
  logic        halted;
  logic [31:0] pc_out;

  fetch_unit #(.ADDR_W(6)) dut (
    .clock(clock), .reset(reset), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .IF_ID(IF_ID), .if_valid(if_valid),
    .halted(halted), .pc_out(pc_out)
  );

  typedef struct {
    int          tag;
    int          step;
    logic [63:0] if_id;
    logic        valid;
    logic        halt;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   step_n = 0;
  bit   done   = 0;

  localparam logic [31:0] NOP = 32'h38000000;
  localparam logic [31:0] HLT = 32'h34000000;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: compare every queued expectation whose edge has just passed.
  initial begin
    exp_t e;
    while (!done) begin
      @(posedge clock);
      #1;
      while (exp_q.size() > 0 && exp_q[0].tag <= cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (e.tag != cyc) begin
          errors++;
          $display("FAIL step%0d timing: checked at cycle %0d, required %0d", e.step, cyc, e.tag);
        end
        checks++;
        if (IF_ID !== e.if_id) begin
          errors++;
          $display("FAIL step%0d IF_ID: got %h required %h", e.step, IF_ID, e.if_id);
        end
        checks++;
        if (if_valid !== e.valid) begin
          errors++;
          $display("FAIL step%0d if_valid: got %b required %b", e.step, if_valid, e.valid);
        end
        checks++;
        if (halted !== e.halt) begin
          errors++;
          $display("FAIL step%0d halted: got %b required %b", e.step, halted, e.halt);
        end
        checks++;
        if (pc_out !== e.pc) begin
          errors++;
          $display("FAIL step%0d pc_out: got %h required %h", e.step, pc_out, e.pc);
        end
      end
    end
  end

  // Called just after a negedge: drive inputs, queue the result expected
  // after the next posedge, then advance to the following negedge.
  task automatic step(input logic rst, input logic st, input logic br,
                      input logic [31:0] tgt, input logic we,
                      input logic [5:0] wa, input logic [31:0] wd,
                      input logic [63:0] e_ifid, input logic e_v,
                      input logic e_h, input logic [31:0] e_pc);
    exp_t e;
    reset      = rst;
    stall      = st;
    br_taken   = br;
    br_target  = tgt;
    imem_we    = we;
    imem_addr  = wa;
    imem_wdata = wd;
    step_n++;
    e.tag   = cyc + 1;
    e.step  = step_n;
    e.if_id = e_ifid;
    e.valid = e_v;
    e.halt  = e_h;
    e.pc    = e_pc;
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = 32'h0;
    imem_we = 1'b0; imem_addr = 6'd0; imem_wdata = 32'h0;
    @(negedge clock);

    // Load program while held in reset; outputs stay at reset values.
    step(1, 0, 0, 32'h0, 1, 6'd0,  32'h00221800, {32'h0, NOP}, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0, 1, 6'd1,  32'h04221800, {32'h0, NOP}, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0, 1, 6'd2,  32'h14221800, {32'h0, NOP}, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0, 1, 6'd3,  HLT,          {32'h0, NOP}, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0, 1, 6'd5,  32'h20000005, {32'h0, NOP}, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0, 1, 6'd16, 32'h0C000010, {32'h0, NOP}, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0, 1, 6'd17, 32'h08000011, {32'h0, NOP}, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0, 1, 6'd63, 32'h2800003F, {32'h0, NOP}, 0, 0, 32'h0);

    // Sequential fetch, stall, release.
    step(0, 0, 0, 32'h0, 0, 6'd0, 32'h0, 64'h00000000_00221800, 1, 0, 32'h1);
    step(0, 0, 0, 32'h0, 0, 6'd0, 32'h0, 64'h00000001_04221800, 1, 0, 32'h2);
    step(0, 1, 0, 32'h0, 0, 6'd0, 32'h0, 64'h00000001_04221800, 1, 0, 32'h2);
    step(0, 1, 0, 32'h0, 0, 6'd0, 32'h0, 64'h00000001_04221800, 1, 0, 32'h2);
    step(0, 0, 0, 32'h0, 0, 6'd0, 32'h0, 64'h00000002_14221800, 1, 0, 32'h3);

    // Branch back to 2, then branch-with-stall at pc=2 to 0x10.
    step(0, 0, 1, 32'h2,  0, 6'd0, 32'h0, {32'h3, NOP}, 0, 0, 32'h2);
    step(0, 1, 1, 32'h10, 0, 6'd0, 32'h0, {32'h2, NOP}, 0, 0, 32'h10);
    step(0, 0, 0, 32'h0,  0, 6'd0, 32'h0, 64'h00000010_0C000010, 1, 0, 32'h11);
    step(0, 0, 0, 32'h0,  0, 6'd0, 32'h0, 64'h00000011_08000011, 1, 0, 32'h12);

    // Halt at pc=3, stay halted (also under stall), branch out to 0.
    step(0, 0, 1, 32'h3, 0, 6'd0, 32'h0, {32'h12, NOP}, 0, 0, 32'h3);
    step(0, 0, 0, 32'h0, 0, 6'd0, 32'h0, {32'h3, HLT},  1, 1, 32'h3);
    step(0, 0, 0, 32'h0, 0, 6'd0, 32'h0, {32'h3, NOP},  0, 1, 32'h3);
    step(0, 1, 0, 32'h0, 0, 6'd0, 32'h0, {32'h3, NOP},  0, 1, 32'h3);
    step(0, 0, 0, 32'h0, 0, 6'd0, 32'h0, {32'h3, NOP},  0, 1, 32'h3);
    step(0, 0, 1, 32'h0, 0, 6'd0, 32'h0, {32'h3, NOP},  0, 0, 32'h0);
    step(0, 0, 0, 32'h0, 0, 6'd0, 32'h0, 64'h00000000_00221800, 1, 0, 32'h1);

    // Index wrap: pc=64 reads imem[0].
    step(0, 0, 1, 32'd64, 0, 6'd0, 32'h0, {32'h1, NOP}, 0, 0, 32'd64);
    step(0, 0, 0, 32'h0,  0, 6'd0, 32'h0, 64'h00000040_00221800, 1, 0, 32'd65);

    // Write/fetch collision on index 5: old word first, new word after refetch.
    step(0, 0, 1, 32'h5, 0, 6'd0, 32'h0,          {32'd65, NOP}, 0, 0, 32'h5);
    step(0, 0, 0, 32'h0, 1, 6'd5, 32'h24000055,   64'h00000005_20000005, 1, 0, 32'h6);
    step(0, 0, 1, 32'h5, 0, 6'd0, 32'h0,          {32'h6, NOP}, 0, 0, 32'h5);
    step(0, 0, 0, 32'h0, 0, 6'd0, 32'h0,          64'h00000005_24000055, 1, 0, 32'h6);

    // 32-bit PC wrap.
    step(0, 0, 1, 32'hFFFFFFFF, 0, 6'd0, 32'h0, {32'h6, NOP}, 0, 0, 32'hFFFFFFFF);
    step(0, 0, 0, 32'h0,        0, 6'd0, 32'h0, 64'hFFFFFFFF_2800003F, 1, 0, 32'h0);

    // Reset while halted wins over simultaneous branch and stall.
    step(0, 0, 1, 32'h3,  0, 6'd0, 32'h0, {32'h0, NOP}, 0, 0, 32'h3);
    step(0, 0, 0, 32'h0,  0, 6'd0, 32'h0, {32'h3, HLT}, 1, 1, 32'h3);
    step(1, 1, 1, 32'h10, 0, 6'd0, 32'h0, {32'h0, NOP}, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0,  0, 6'd0, 32'h0, 64'h00000000_00221800, 1, 0, 32'h1);

    repeat (3) @(negedge clock);
    done = 1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
